// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the CPU store port: byte stores to TX_ADDR
// are queued in a FIFO and sent 8N1, LSB first, on tx.
module mmio_uart_tx #(
    parameter logic [31:0] TX_ADDR      = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          data_write,
    input  logic [7:0]                    data,
    input  logic [31:0]                   data_address,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [15:0]   baud;
    logic [15:0]   baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [7:0]    shift;
    logic          tx_next;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          baud_done;

    // A full FIFO still accepts a store when the head leaves in the same cycle.
    assign push_req  = data_write && (data_address == TX_ADDR);
    assign push      = push_req && ((count != DEPTH_C) || pop);
    assign baud_done = (baud == BAUD_LAST);

    always_comb begin
        state_next = state;
        baud_next  = baud + 16'd1;
        bit_next   = bit_idx;
        pop        = 1'b0;
        tx_next    = 1'b1;
        case (state)
            IDLE: begin
                baud_next = 16'd0;
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (baud_done) begin
                    baud_next  = 16'd0;
                    bit_next   = 3'd0;
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift[0];
                if (baud_done) begin
                    baud_next = 16'd0;
                    bit_next  = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_next = 16'd0;
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            baud      <= 16'd0;
            bit_idx   <= 3'd0;
            tx        <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_next;
            baud      <= baud_next;
            bit_idx   <= bit_next;
            tx        <= tx_next;
            count     <= count_next;
            fifo_full <= (count_next == DEPTH_C);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Data path: FIFO storage and shift register carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
        if (pop) begin
            shift <= mem[rd_ptr];
        end else if (state == DATA && baud_done) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

    assign fifo_count = count;
    assign busy       = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a frame-level model predicts accepted bytes,
// pop times and status; a line monitor decodes tx frames and checks them.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

    localparam logic [31:0] TX_ADDR = 32'hFFFF_0000;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_write = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [31:0] data_address = 32'h0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        overflow;

    mmio_uart_tx #(
        .TX_ADDR(TX_ADDR),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_write(data_write),
        .data(data),
        .data_address(data_address),
        .tx(tx),
        .busy(busy),
        .fifo_full(fifo_full),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         pe;
    } ent_t;

    ent_t pend_q[$];
    ent_t exp_q[$];
    int   cyc = 0;
    int   last_pop = -1000;
    int   m_count = 0;
    bit   m_busy = 1'b0;
    bit   m_ovf = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   in_frame = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Frames start back to back: a waiting byte leaves FRAME cycles after the previous
    // one, or one cycle after its own store when the line is idle.
    function automatic int next_pop();
        int a;
        int b;
        if (pend_q.size() == 0) return -1;
        a = pend_q[0].pe + 1;
        b = last_pop + FRAME;
        return (a > b) ? a : b;
    endfunction

    function automatic void model_reset();
        pend_q.delete();
        exp_q.delete();
        last_pop = -1000;
        m_count  = 0;
        m_busy   = 1'b0;
        m_ovf    = 1'b0;
    endfunction

    function automatic void model_tick(input logic dw, input logic [7:0] d, input logic [31:0] a);
        bit   pop_now;
        bit   acc;
        ent_t e;
        pop_now = (next_pop() == cyc);
        acc = 1'b0;
        if (dw && a == TX_ADDR) begin
            if (pend_q.size() < DEPTH || pop_now) acc = 1'b1;
            else m_ovf = 1'b1;
        end
        if (pop_now) begin
            e = pend_q.pop_front();
            e.pe = cyc;
            exp_q.push_back(e);
            last_pop = cyc;
        end
        if (acc) begin
            e.b  = d;
            e.pe = cyc;
            pend_q.push_back(e);
        end
        m_count = pend_q.size();
        m_busy  = (m_count != 0) || (cyc < last_pop + FRAME);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) model_reset();
            else model_tick(data_write, data, data_address);
        end
    end

    initial begin
        ent_t       cur;
        int         pos;
        bit         glitch;
        logic [9:0] frame_bits;
        logic [9:0] got;
        logic [3:0] bi;
        pos = 0;
        glitch = 1'b0;
        frame_bits = '0;
        got = '0;
        forever begin
            @(negedge clk);
            chk("fifo_count", 32'(fifo_count), 32'(m_count));
            chk("fifo_full", 32'(fifo_full), 32'(m_count == DEPTH));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (reset) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && tx === 1'b0) begin
                    chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        chk("start_latency", 32'(cyc), 32'(cur.pe + 1));
                        in_frame   = 1'b1;
                        pos        = 0;
                        glitch     = 1'b0;
                        got        = '0;
                        frame_bits = {1'b1, cur.b, 1'b0};
                    end
                end
                if (in_frame) begin
                    bi = 4'(pos / CPB);
                    if (tx !== frame_bits[bi]) glitch = 1'b1;
                    if (pos % CPB == CPB / 2) got[bi] = tx;
                    pos++;
                    if (pos == FRAME) begin
                        chk("frame", {21'd0, glitch, got}, {22'd0, frame_bits});
                        in_frame = 1'b0;
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic store(input logic [7:0] d, input logic [31:0] a);
        data_write   = 1'b1;
        data         = d;
        data_address = a;
        @(posedge clk);
        #1;
        data_write   = 1'b0;
        data         = 8'($urandom);
        data_address = TX_ADDR;
    endtask

    task automatic hit_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        idle(2);
        reset = 1'b0;
        idle(2);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((pend_q.size() != 0 || m_busy || exp_q.size() != 0 || in_frame) && n < 2000) begin
            idle(1);
            n++;
        end
        chk("drain_bound", 32'(n < 2000), 32'd1);
        idle(2);
    endtask

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int n;
        idle(3);
        chk("init_tx", 32'(tx), 32'd1);
        chk("init_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        idle(2);

        // Reset while the start bit is on the line
        store(8'hA5, TX_ADDR);
        chk("s1_count", 32'(fifo_count), 32'd1);
        idle(1);
        chk("s1_tx_pop_edge", 32'(tx), 32'd1);
        idle(1);
        chk("s1_tx_start", 32'(tx), 32'd0);
        hit_reset();

        // Single byte, full frame and busy timing
        store(8'hA5, TX_ADDR);
        idle(1);
        chk("s2_tx_high", 32'(tx), 32'd1);
        idle(1);
        chk("s2_tx_fall", 32'(tx), 32'd0);
        idle(38);
        chk("s2_busy_last", 32'(busy), 32'd1);
        idle(1);
        chk("s2_busy_drop", 32'(busy), 32'd0);
        idle(4);
        chk("s2_tx_idle", 32'(tx), 32'd1);

        // Ignored stores
        store(8'h55, TX_ADDR + 32'd4);
        data_write = 1'b0;
        data = 8'h55;
        data_address = TX_ADDR;
        idle(10);
        chk("s3_tx", 32'(tx), 32'd1);
        chk("s3_count", 32'(fifo_count), 32'd0);
        chk("s3_busy", 32'(busy), 32'd0);

        // Six back-to-back stores into an idle transmitter
        for (int i = 1; i <= 6; i++) begin
            store(8'(i), TX_ADDR);
            if (i == 2) chk("s4_first_popped", 32'(fifo_count), 32'd1);
            if (i == 5) begin
                chk("s4_full", 32'(fifo_full), 32'd1);
                chk("s4_no_ovf_yet", 32'(overflow), 32'd0);
            end
            if (i == 6) begin
                chk("s4_ovf", 32'(overflow), 32'd1);
                chk("s4_count_full", 32'(fifo_count), 32'd4);
            end
        end
        drain();

        // Store while full on the pop cycle
        hit_reset();
        for (int i = 0; i < 5; i++) store(8'h11 + 8'(i), TX_ADDR);
        chk("s5_full", 32'(fifo_full), 32'd1);
        n = 0;
        while (next_pop() != cyc + 1 && n < 200) begin
            idle(1);
            n++;
        end
        chk("s5_wait_bound", 32'(n < 200), 32'd1);
        store(8'h16, TX_ADDR);
        chk("s5_count", 32'(fifo_count), 32'd4);
        chk("s5_ovf", 32'(overflow), 32'd0);
        drain();

        // Reset in the middle of DATA with bytes queued
        for (int i = 0; i < 4; i++) store(8'h21 + 8'(i), TX_ADDR);
        chk("s6_queued", 32'(fifo_count), 32'd3);
        idle(10);
        hit_reset();
        idle(60);
        chk("s6_tx_quiet", 32'(tx), 32'd1);
        chk("s6_busy_quiet", 32'(busy), 32'd0);
        store(8'h3C, TX_ADDR);
        drain();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            n = int'($urandom_range(0, 9));
            if (n < 2) store(8'($urandom), TX_ADDR);
            else if (n == 2) store(8'($urandom), TX_ADDR + 32'(4 * $urandom_range(1, 4)));
            else idle(1);
        end
        drain();
        chk("final_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("final_tx", 32'(tx), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
